// File: rtl/bpsk_symbol_demod.sv
// BPSK symbol demodulator: counts per-symbol agreement with a local square-wave carrier,
// slices bits into words and hands them off through a one-deep buffer. Optional macro: DEMOD_ERASURE_EN.
module bpsk_symbol_demod #(
  parameter int WAVELENGTH     = 16,
  parameter int PAYLOAD_BITS   = 8,
  parameter int FRAME_WORDS    = 4,
  parameter int ERASURE_MARGIN = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    signal,
  input  logic                    corr_done,
  output logic [PAYLOAD_BITS-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_erasure,
  output logic                    frame_active,
  output logic                    overrun
);

  localparam int PW   = $clog2(WAVELENGTH);
  localparam int AW   = PW + 1;
  localparam int BW   = $clog2(PAYLOAD_BITS + 1);
  localparam int WW   = $clog2(FRAME_WORDS + 1);
  localparam int HALF = WAVELENGTH / 2;

  typedef enum logic {SEARCH, RECEIVE} state_t;

  state_t                  state, state_nxt;
  logic [PW-1:0]           phase;
  logic [AW-1:0]           acc;
  logic [BW-1:0]           bit_cnt;
  logic [WW-1:0]           word_cnt;
  logic [PAYLOAD_BITS-1:0] shreg;

  logic                    ref_bit;
  logic                    match;
  logic                    sym_end;
  logic                    word_done;
  logic                    frame_done;
  logic                    bit_val;
  logic [AW-1:0]           acc_total;
  logic [PAYLOAD_BITS-1:0] word_next;

  always_comb begin
    ref_bit    = (phase < PW'(HALF));
    match      = ~(signal ^ ref_bit);
    acc_total  = acc + AW'(match);
    bit_val    = (acc_total > AW'(HALF));
    sym_end    = (state == RECEIVE) && (phase == PW'(WAVELENGTH - 1));
    word_done  = sym_end && (bit_cnt == BW'(PAYLOAD_BITS - 1));
    frame_done = word_done && (word_cnt == WW'(FRAME_WORDS - 1));
    word_next  = {shreg[PAYLOAD_BITS-2:0], bit_val};
  end

  always_ff @(posedge clk) begin
    if (reset) state <= SEARCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    frame_active = 1'b0;
    case (state)
      SEARCH: begin
        if (corr_done) state_nxt = RECEIVE;
      end
      RECEIVE: begin
        frame_active = 1'b1;
        if (frame_done) state_nxt = SEARCH;
      end
      default: state_nxt = SEARCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase    <= '0;
      acc      <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
      shreg    <= '0;
    end else if (state == RECEIVE) begin
      if (sym_end) begin
        phase   <= '0;
        acc     <= '0;
        shreg   <= word_next;
        bit_cnt <= word_done ? '0 : bit_cnt + BW'(1);
        if (word_done) word_cnt <= frame_done ? '0 : word_cnt + WW'(1);
      end else begin
        phase <= phase + PW'(1);
        acc   <= acc_total;
      end
    end else begin
      phase    <= '0;
      acc      <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
    end
  end

  // The last bit is merged combinationally so the word lands in the buffer on its own sample edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (word_done) begin
      if (!out_valid || out_ready) begin
        out_data  <= word_next;
        out_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef DEMOD_ERASURE_EN
  logic [AW-1:0] dist;
  logic          low_conf;
  logic          eras_flag;
  logic          cand_eras;

  always_comb begin
    dist      = (acc_total >= AW'(HALF)) ? acc_total - AW'(HALF) : AW'(HALF) - acc_total;
    low_conf  = (dist <= AW'(ERASURE_MARGIN));
    cand_eras = eras_flag | low_conf;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      eras_flag   <= 1'b0;
      out_erasure <= 1'b0;
    end else begin
      if (sym_end) eras_flag <= word_done ? 1'b0 : cand_eras;
      if (word_done && (!out_valid || out_ready)) out_erasure <= cand_eras;
    end
  end
`else
  assign out_erasure = 1'b0;
`endif

endmodule

// File: doc/bpsk_symbol_demod.md
Name: bpsk_symbol_demod

Overview:
- Receive stage directly downstream of the binary preamble correlator.
- Idles in SEARCH until the correlator reports a preamble match (`corr_done`).
- Then demodulates a fixed-length payload from the 1-bit sliced receive stream: per-symbol agreement count against a locally generated carrier, hard bit decision, assembly into words.
- Words go to the packet layer over a valid/ready handshake with a one-deep output buffer.

Parameters:
- WAVELENGTH, 16, samples per symbol; even, ≥4.
- PAYLOAD_BITS, 8, bits per output word.
- FRAME_WORDS, 4, words per frame after the preamble.
- ERASURE_MARGIN, 2, agreement-count band around WAVELENGTH/2 flagged as unreliable (only used with the optional feature).

Ports:
- clk, input, 1, system clock; all logic on its rising edge.
- reset, input, 1, synchronous active-high reset.
- signal, input, 1, sliced receive sample; same stream the correlator sees.
- corr_done, input, 1, correlator match; level, may stay high several cycles.
- out_data, output, PAYLOAD_BITS, demodulated word; first-received bit is the MSB.
- out_valid, output, 1, out_data holds an unconsumed word.
- out_ready, input, 1, consumer accepts the word when out_valid && out_ready.
- out_erasure, output, 1, word contains at least one low-confidence symbol.
- frame_active, output, 1, high while in RECEIVE.
- overrun, output, 1, sticky: a word was dropped because the buffer was full.

Behaviour:
- Reset values: state=SEARCH; phase, bit and word counters = 0; agreement accumulator = 0; shift register = 0. Outputs: out_data=0, out_valid=0, out_erasure=0, frame_active=0, overrun=0. Reset mid-frame aborts the frame and discards any buffered word.
- SEARCH:
  - `signal` is ignored.
  - corr_done=1 sampled at edge N moves to RECEIVE; the sample on edge N+1 is phase 0 of symbol 0.
- RECEIVE:
  - frame_active=1; corr_done is ignored.
  - Local carrier ref = 1 when phase < WAVELENGTH/2, else 0.
  - Every cycle: match = ~(signal ^ ref). The accumulator (width clog2(WAVELENGTH)+1) adds match; phase increments and wraps at WAVELENGTH-1.
  - At phase WAVELENGTH-1 (include this cycle's match; total = A):
    - bit = 1 if A > WAVELENGTH/2, else 0. A tie gives 0.
    - Shift the bit into the word register LSB-first-in, so the first bit ends up as MSB.
    - Clear the accumulator and increment the bit counter.
- Word completion (bit counter reaches PAYLOAD_BITS):
  - Candidate word is presented to the buffer on the edge following the last sample; out_valid rises 1 cycle after that sample.
  - Buffer empty, or out_valid && out_ready in the same cycle: load word, out_valid=1, no overrun.
  - Buffer full and out_ready=0: drop the new word, hold the old word, set overrun=1 (sticky until reset).
  - Bit counter clears; word counter increments.
- Frame end: after word FRAME_WORDS is produced, return to SEARCH on the same edge, so frame_active drops 1 cycle after the last sample. corr_done can be accepted on the very next edge.
- The output buffer drains independently of state. out_valid falls on the edge after out_valid && out_ready when no new word loads on that edge.
- No back-pressure on `signal`: samples are never stalled.

Optional Feature:
- Macro DEMOD_ERASURE_EN.
- Defined: a symbol is low-confidence when |A - WAVELENGTH/2| ≤ ERASURE_MARGIN. A per-word sticky flag ORs low-confidence symbols; it loads into out_erasure together with out_data and clears at the word boundary.
- Undefined: the comparator and flag are not built; out_erasure is tied to 0. The port list is unchanged.

Test Plan (WAVELENGTH=16, PAYLOAD_BITS=8, FRAME_WORDS=2, ERASURE_MARGIN=2, out_ready=1 unless stated):
1. Pulse corr_done 1 cycle, then feed clean symbols for 0xA5, 0x3C (ref pattern for 1, inverted for 0) -> out_data=0xA5 valid 1 cycle after sample 128, then 0x3C after sample 256; frame_active drops with the second word; overrun=0.
2. Hold corr_done high 5 cycles at start -> exactly one frame; symbol 0 starts 1 cycle after the first high sample; later corr_done cycles are ignored.
3. out_ready=0 through the whole frame -> 0xA5 held, 0x3C dropped, overrun=1 and stays 1 after out_ready rises; the next frame still delivers words.
4. Flip 7 of 16 samples in bit 0 of word 0 (A=9) -> still decodes 0xA5. With DEMOD_ERASURE_EN: out_erasure=1 on word 0 and 0 on word 1. Without it: out_erasure=0.
5. Exact tie A=8 on the last bit of 0xA5 -> out_data=0xA4.
6. Assert reset at sample 70 of frame, release, then re-trigger -> all outputs at reset values; the fresh frame decodes correctly with no stale bits.
